// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan
//  Purpose  : 3x4 keypad column scanner with row sync, frame debounce and
//             single-cycle key events.
//  Options  : KEYPAD_REPEAT_EN enables auto-repeat of the held key.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scan #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 64
) (
    input  logic        clk_1,
    input  logic        rst,
    input  logic [3:0]  KEY_ROW,
    output logic [2:0]  KEY_COL,
    output logic [11:0] key_state,
    output logic        key_any,
    output logic        key_event,
    output logic [3:0]  key_code
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] c_DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] c_DEB_MAX  = SW'(DEBOUNCE_FRAMES);
    localparam logic [1:0]    c_COL_LAST = 2'd2;

    if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
        $error("keypad_scan: illegal parameter set");
    end

    logic [3:0]    r_row_meta, r_row_sync;
    logic [DW-1:0] r_div_cnt;
    logic [1:0]    r_col_idx;
    logic [11:0]   r_frame, r_cand, r_key_state;
    logic [SW-1:0] r_stable;
    logic          r_eval, r_event;
    logic [3:0]    r_code;

    logic          w_slot_end, w_frame_done, w_commit, w_press, w_rep_fire;
    logic [11:0]   w_frame_next, w_newly;
    logic [3:0]    w_low_idx;

    function automatic logic [3:0] f_code(input logic [3:0] idx);
        case (idx)
            4'd9:    return 4'd10;
            4'd10:   return 4'd0;
            4'd11:   return 4'd11;
            default: return idx + 4'd1;
        endcase
    endfunction

    assign w_slot_end   = (r_div_cnt == c_DIV_LAST);
    assign w_frame_done = w_slot_end && (r_col_idx == c_COL_LAST);

    // Frame including the sample taken this cycle, so frame_done sees column 2.
    always_comb begin
        w_frame_next = r_frame;
        case (r_col_idx)
            2'd0: for (int r = 0; r < 4; r++) w_frame_next[r*3]     = r_row_sync[r];
            2'd1: for (int r = 0; r < 4; r++) w_frame_next[r*3 + 1] = r_row_sync[r];
            default: for (int r = 0; r < 4; r++) w_frame_next[r*3 + 2] = r_row_sync[r];
        endcase
    end

    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            r_row_meta <= '0;
            r_row_sync <= '0;
            r_div_cnt  <= '0;
            r_col_idx  <= 2'd0;
            r_frame    <= '0;
        end else begin
            r_row_meta <= KEY_ROW;
            r_row_sync <= r_row_meta;
            if (w_slot_end) begin
                r_div_cnt <= '0;
                r_col_idx <= (r_col_idx == c_COL_LAST) ? 2'd0 : r_col_idx + 2'd1;
                r_frame   <= w_frame_next;
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end
        end
    end

    assign w_commit = r_eval && (r_stable == c_DEB_MAX) && (r_cand != r_key_state);
    assign w_newly  = r_cand & ~r_key_state;
    assign w_press  = w_commit && (|w_newly);

    always_comb begin
        w_low_idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (w_newly[i]) w_low_idx = 4'(i);
        end
    end

    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            r_cand      <= '0;
            r_stable    <= '0;
            r_eval      <= 1'b0;
            r_key_state <= '0;
            r_event     <= 1'b0;
            r_code      <= 4'd0;
        end else begin
            r_eval <= w_frame_done;
            if (w_frame_done) begin
                if (w_frame_next != r_cand) begin
                    r_cand   <= w_frame_next;
                    r_stable <= SW'(1);
                end else if (r_stable != c_DEB_MAX) begin
                    r_stable <= r_stable + SW'(1);
                end
            end
            if (w_commit) r_key_state <= r_cand;
            r_event <= w_press | w_rep_fire;
            if (w_press) r_code <= f_code(w_low_idx);
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] c_REP_LAST = RW'(REPEAT_FRAMES);

    logic [RW-1:0] r_rep_cnt;
    logic [3:0]    r_rep_idx;
    logic          r_rep_active;
    logic [RW-1:0] w_rep_inc;
    logic [11:0]   w_state_next;
    logic          w_rep_held;

    assign w_rep_inc    = r_rep_cnt + RW'(1);
    assign w_state_next = w_commit ? r_cand : r_key_state;
    assign w_rep_held   = w_state_next[r_rep_idx];
    assign w_rep_fire   = r_eval && !w_press && r_rep_active && w_rep_held
                          && (w_rep_inc == c_REP_LAST);

    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            r_rep_cnt    <= '0;
            r_rep_idx    <= 4'd0;
            r_rep_active <= 1'b0;
        end else if (w_press) begin
            r_rep_cnt    <= '0;
            r_rep_idx    <= w_low_idx;
            r_rep_active <= 1'b1;
        end else if (r_eval && r_rep_active) begin
            if (!w_rep_held) begin
                r_rep_active <= 1'b0;
                r_rep_cnt    <= '0;
            end else if (w_rep_inc == c_REP_LAST) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= w_rep_inc;
            end
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign KEY_COL   = 3'b001 << r_col_idx;
    assign key_state = r_key_state;
    assign key_any   = |r_key_state;
    assign key_event = r_event;
    assign key_code  = r_code;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan
//  Purpose  : Self-checking bench for keypad_scan against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DF = 3;
    localparam int RF = 2;

    logic        clk_1 = 1'b0;
    logic        rst   = 1'b0;
    logic [3:0]  KEY_ROW;
    logic [2:0]  KEY_COL;
    logic [11:0] key_state;
    logic        key_any;
    logic        key_event;
    logic [3:0]  key_code;
    logic [11:0] pressed = '0;

    always #5 clk_1 = ~clk_1;

    // Physical keypad: a row returns high when a pressed key sits on the driven column.
    assign KEY_ROW = {|(pressed[11:9] & KEY_COL), |(pressed[8:6] & KEY_COL),
                      |(pressed[5:3] & KEY_COL),  |(pressed[2:0] & KEY_COL)};

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF), .REPEAT_FRAMES(RF)) dut (
        .clk_1(clk_1), .rst(rst), .KEY_ROW(KEY_ROW), .KEY_COL(KEY_COL),
        .key_state(key_state), .key_any(key_any), .key_event(key_event),
        .key_code(key_code)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ev_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model
    int          code_of [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    logic [11:0] m_cand, m_state, prev_map;
    int          m_stable, m_rep_idx, m_rep_cnt;
    logic [3:0]  m_code;
    logic        m_ev, m_rep_on, have_prev;

    task automatic model_reset();
        m_cand = '0; m_state = '0; m_stable = 0; m_code = 4'd0; m_ev = 1'b0;
        m_rep_on = 1'b0; m_rep_idx = 0; m_rep_cnt = 0; have_prev = 1'b0; prev_map = '0;
    endtask

    task automatic model_frame(input logic [11:0] f);
        logic [11:0] newly;
        int low;
        m_ev = 1'b0;
        if (f != m_cand) begin
            m_cand = f;
            m_stable = 1;
        end else if (m_stable < DF) begin
            m_stable++;
        end
        if (m_stable == DF && m_cand != m_state) begin
            newly   = m_cand & ~m_state;
            m_state = m_cand;
            if (newly != 0) begin
                low = 12;
                for (int i = 11; i >= 0; i--) if (newly[i]) low = i;
                m_code = 4'(code_of[low]);
                m_ev = 1'b1; m_rep_on = 1'b1; m_rep_idx = low; m_rep_cnt = 0;
            end
        end
`ifdef KEYPAD_REPEAT_EN
        if (!m_ev && m_rep_on) begin
            if (!m_state[m_rep_idx]) m_rep_on = 1'b0;
            else begin
                m_rep_cnt++;
                if (m_rep_cnt == RF) begin m_rep_cnt = 0; m_ev = 1'b1; end
            end
        end
`endif
    endtask

    // Apply one frame of keypad contents; called at a negedge in the frame's first cycle.
    task automatic run_frame(input logic [11:0] map);
        logic exp_ev;
        pressed = map;
        for (int off = 1; off <= 12; off++) begin
            @(negedge clk_1);
            exp_ev = 1'b0;
            if (off == 1 && have_prev) begin
                model_frame(prev_map);
                exp_ev = m_ev;
            end
            if (key_event) ev_seen++;
            check("key_col",   32'(KEY_COL), 32'(3'b001 << ((off % 12) / 4)));
            check("key_event", 32'(key_event), 32'(exp_ev));
            check("key_state", 32'(key_state), 32'(m_state));
            check("key_any",   32'(key_any), 32'(|m_state));
            check("key_code",  32'(key_code), 32'(m_code));
        end
        prev_map  = map;
        have_prev = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk_1);
        rst = 1'b0;
        pressed = '0;
        @(negedge clk_1);
        check("rst_col",   32'(KEY_COL), 32'h1);
        check("rst_state", 32'(key_state), 32'h0);
        check("rst_any",   32'(key_any), 32'h0);
        check("rst_event", 32'(key_event), 32'h0);
        check("rst_code",  32'(key_code), 32'h0);
        @(negedge clk_1);
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [11:0] map;
        int          frames;
        logic [11:0] exp_state;
        logic [3:0]  exp_code;
        int          exp_events;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int ev0, hold;
        logic [11:0] rmap;

        vecs[0] = '{12'h000, 2, 12'h000, 4'd0,  0};
        vecs[1] = '{12'h002, 4, 12'h002, 4'd2,  1};
        vecs[2] = '{12'h000, 4, 12'h000, 4'd2,  0};
        vecs[3] = '{12'h400, 2, 12'h000, 4'd2,  0};
        vecs[4] = '{12'h000, 2, 12'h000, 4'd2,  0};
        vecs[5] = '{12'h400, 2, 12'h000, 4'd2,  0};
        vecs[6] = '{12'h400, 4, 12'h400, 4'd0,  1};
        vecs[7] = '{12'h000, 4, 12'h000, 4'd0,  0};
        vecs[8] = '{12'hA00, 4, 12'hA00, 4'd10, 1};
        vecs[9] = '{12'h000, 4, 12'h000, 4'd10, 0};

        model_reset();
        do_reset();
        for (int v = 0; v < 10; v++) begin
            ev0 = ev_seen;
            for (int f = 0; f < vecs[v].frames; f++) run_frame(vecs[v].map);
            check($sformatf("vec%0d_state", v), 32'(key_state), 32'(vecs[v].exp_state));
            check($sformatf("vec%0d_code", v),  32'(key_code),  32'(vecs[v].exp_code));
`ifndef KEYPAD_REPEAT_EN
            check($sformatf("vec%0d_events", v), 32'(ev_seen - ev0), 32'(vecs[v].exp_events));
`endif
        end

        // Randomised key maps held for random numbers of frames
        for (int s = 0; s < 20; s++) begin
            rmap = 12'($urandom) & 12'($urandom);
            if ($urandom_range(0, 3) == 0) rmap = '0;
            hold = $urandom_range(1, 5);
            for (int f = 0; f < hold; f++) run_frame(rmap);
        end

        // Reset in the cycle before a pending commit must suppress the event
        do_reset();
        run_frame(12'h004);
        run_frame(12'h004);
        pressed = 12'h004;
        for (int off = 1; off <= 12; off++) begin
            @(negedge clk_1);
            check("mid_noevent", 32'(key_event), 32'h0);
        end
        rst = 1'b0;
        #1;
        check("mid_state", 32'(key_state), 32'h0);
        check("mid_any",   32'(key_any), 32'h0);
        check("mid_code",  32'(key_code), 32'h0);
        check("mid_col",   32'(KEY_COL), 32'h1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_1);
            check("mid_rst_event", 32'(key_event), 32'h0);
        end
        @(negedge clk_1);
        rst = 1'b1;
        model_reset();
        ev0 = ev_seen;
        for (int f = 0; f < 4; f++) run_frame(12'h004);
        check("mid_recover_events", 32'(ev_seen - ev0), 32'h1);
        check("mid_recover_code",   32'(key_code), 32'h3);

        // Long hold of "5": one event, or periodic repeats when enabled
        do_reset();
        ev0 = ev_seen;
        for (int f = 0; f < 8; f++) run_frame(12'h010);
`ifdef KEYPAD_REPEAT_EN
        check("hold5_events", 32'(ev_seen - ev0), 32'h3);
`else
        check("hold5_events", 32'(ev_seen - ev0), 32'h1);
`endif
        check("hold5_code", 32'(key_code), 32'h5);
        for (int f = 0; f < 4; f++) run_frame(12'h000);
        check("hold5_release", 32'(key_state), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
